// File: rtl/rf_writeback_arbiter.sv
// Merges execute and load write-back onto the single register-file write port
// and tracks pending writes per register for issue-stage hazard checks.
module rf_writeback_arbiter #(
    parameter int REGI_DEPTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ex_valid,
    output logic                          ex_ready,
    input  logic [$clog2(REGI_DEPTH)-1:0] ex_waddr,
    input  logic [DATA_WIDTH-1:0]         ex_wdata,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [$clog2(REGI_DEPTH)-1:0] ld_waddr,
    input  logic [DATA_WIDTH-1:0]         ld_wdata,
    input  logic                          rsv_valid,
    input  logic [$clog2(REGI_DEPTH)-1:0] rsv_addr,
    input  logic [$clog2(REGI_DEPTH)-1:0] chk_addr1,
    input  logic [$clog2(REGI_DEPTH)-1:0] chk_addr2,
    output logic                          chk_busy1,
    output logic                          chk_busy2,
    output logic                          rf_wen,
    output logic [$clog2(REGI_DEPTH)-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    output logic                          rsv_err,
    output logic                          idle
);

    localparam int AW = $clog2(REGI_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]         starve_cnt;
    logic                  starved;
    logic                  ex_fire;
    logic                  ld_fire;
    logic [REGI_DEPTH-1:0] busy;
    logic [REGI_DEPTH-1:0] busy_next;
    logic                  rsv_conflict;

    // Loads normally win; a starved execute request flips the priority for one grant.
    assign starved  = (starve_cnt == CW'(STARVE_LIMIT));
    assign ex_ready = starved ? 1'b1 : !ld_valid;
    assign ld_ready = starved ? !ex_valid : 1'b1;
    assign ex_fire  = ex_valid && ex_ready;
    assign ld_fire  = ld_valid && ld_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!ex_valid || ex_fire) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (ld_fire) begin
            rf_wen   <= (ld_waddr != '0);
            rf_waddr <= ld_waddr;
            rf_wdata <= ld_wdata;
        end else if (ex_fire) begin
            rf_wen   <= (ex_waddr != '0);
            rf_waddr <= ex_waddr;
            rf_wdata <= ex_wdata;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // A reservation landing on the same edge as the retiring write keeps the bit set.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < REGI_DEPTH; i++) begin
            if (rsv_valid && rsv_addr == AW'(i)) begin
                busy_next[i] = 1'b1;
            end else if (rf_wen && rf_waddr == AW'(i)) begin
                busy_next[i] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    assign rsv_conflict = rsv_valid && (rsv_addr != '0) && busy[rsv_addr]
                          && !(rf_wen && rf_waddr == rsv_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (rsv_conflict) begin
                rsv_err <= 1'b1;
            end
        end
    end

    assign chk_busy1 = (chk_addr1 != '0) && busy[chk_addr1];
    assign chk_busy2 = (chk_addr2 != '0) && busy[chk_addr2];
    assign idle      = (busy == '0) && !rf_wen;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed self-checking bench for rf_writeback_arbiter: handshake, scoreboard,
// starvation, register-zero, reservation boundary and asynchronous reset.
module tb_rf_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_waddr;
    logic [63:0] ex_wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_waddr;
    logic [63:0] ld_wdata;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        rsv_err;
    logic        idle;

    int assertCount = 0;
    int failCount   = 0;

    rf_writeback_arbiter #(
        .REGI_DEPTH(32),
        .DATA_WIDTH(64),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_waddr(ld_waddr),
        .ld_wdata(ld_wdata),
        .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr),
        .chk_addr1(chk_addr1),
        .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1),
        .chk_busy2(chk_busy2),
        .rf_wen(rf_wen),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .rsv_err(rsv_err),
        .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic exV, input logic [4:0] exA, input logic [63:0] exD,
                                 input logic ldV, input logic [4:0] ldA, input logic [63:0] ldD,
                                 input logic rsvV, input logic [4:0] rsvA);
        ex_valid  = exV;
        ex_waddr  = exA;
        ex_wdata  = exD;
        ld_valid  = ldV;
        ld_waddr  = ldA;
        ld_wdata  = ldD;
        rsv_valid = rsvV;
        rsv_addr  = rsvA;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        chk_addr1 = 5'd0;
        chk_addr2 = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset values
        checkOutput("reset_rf_wen", rf_wen, 0);
        checkOutput("reset_rf_waddr", rf_waddr, 0);
        checkOutput("reset_rf_wdata", rf_wdata, 0);
        checkOutput("reset_idle", idle, 1);
        checkOutput("reset_rsv_err", rsv_err, 0);
        checkOutput("reset_ex_ready", ex_ready, 1);
        checkOutput("reset_ld_ready", ld_ready, 1);
        @(posedge clk);
        #3;
        checkOutput("reset_hold_rf_wen", rf_wen, 0);
        rst = 1'b1;
        tick();

        // Single execute write
        applyStimulus(1, 5'd5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0);
        checkOutput("ex_single_ready", ex_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ex_single_wen", rf_wen, 1);
        checkOutput("ex_single_waddr", rf_waddr, 5);
        checkOutput("ex_single_wdata", rf_wdata, 64'hDEAD_BEEF);
        tick();
        checkOutput("ex_single_wen_drop", rf_wen, 0);
        checkOutput("ex_single_idle", idle, 1);

        // Scoreboard reserve and clear through a load write
        chk_addr1 = 5'd7;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        checkOutput("sb_no_forward", chk_busy1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sb_busy_c1", chk_busy1, 1);
        checkOutput("sb_not_idle", idle, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 1, 5'd7, 64'h77, 0, 0);
        checkOutput("sb_ld_ready", ld_ready, 1);
        checkOutput("sb_busy_c3", chk_busy1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sb_wen_c4", rf_wen, 1);
        checkOutput("sb_waddr_c4", rf_waddr, 7);
        checkOutput("sb_wdata_c4", rf_wdata, 64'h77);
        checkOutput("sb_busy_c4", chk_busy1, 1);
        tick();
        checkOutput("sb_busy_c5", chk_busy1, 0);
        checkOutput("sb_idle_c5", idle, 1);

        // Starvation: loads win four times, execute wins the fifth, loads again after
        for (int k = 0; k < 8; k++) begin
            logic expEx;
            logic [4:0] prevAddr;
            logic [63:0] prevData;
            expEx = (k == 4);
            applyStimulus(1, 5'd10, 64'hE0 + 64'(k), 1, 5'd11, 64'hD0 + 64'(k), 0, 0);
            checkOutput($sformatf("starve_ex_ready_%0d", k), ex_ready, expEx);
            checkOutput($sformatf("starve_ld_ready_%0d", k), ld_ready, !expEx);
            if (k > 0) begin
                prevAddr = (k - 1 == 4) ? 5'd10 : 5'd11;
                prevData = (k - 1 == 4) ? 64'hE0 + 64'(k - 1) : 64'hD0 + 64'(k - 1);
                checkOutput($sformatf("starve_waddr_%0d", k), rf_waddr, prevAddr);
                checkOutput($sformatf("starve_wdata_%0d", k), rf_wdata, prevData);
            end
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("starve_last_waddr", rf_waddr, 11);
        checkOutput("starve_last_wdata", rf_wdata, 64'hD7);
        tick();

        // Register 0 never writes nor reserves
        chk_addr1 = 5'd0;
        applyStimulus(1, 5'd0, 64'h1234, 0, 0, 0, 0, 0);
        checkOutput("r0_ex_ready", ex_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0);
        checkOutput("r0_no_wen", rf_wen, 0);
        checkOutput("r0_wdata_loaded", rf_wdata, 64'h1234);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_chk_busy", chk_busy1, 0);
        checkOutput("r0_rsv_err", rsv_err, 0);
        checkOutput("r0_idle", idle, 1);

        // Reservation coinciding with clear, then a genuine double reservation
        chk_addr2 = 5'd3;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd3, 64'h33, 0, 0);
        checkOutput("bnd_busy3_set", chk_busy2, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3);
        checkOutput("bnd_wen3", rf_wen, 1);
        checkOutput("bnd_waddr3", rf_waddr, 3);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3);
        checkOutput("bnd_set_wins", chk_busy2, 1);
        checkOutput("bnd_no_err", rsv_err, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("bnd_err_set", rsv_err, 1);
        tick();
        tick();
        checkOutput("bnd_err_sticky", rsv_err, 1);

        // Asynchronous reset while a write is in flight
        chk_addr1 = 5'd9;
        chk_addr2 = 5'd9;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
        tick();
        applyStimulus(1, 5'd9, 64'h99, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_pre_wen", rf_wen, 1);
        checkOutput("rst_pre_busy9", chk_busy1, 1);
        rst = 1'b0;
        #1;
        checkOutput("rst_async_wen", rf_wen, 0);
        checkOutput("rst_async_busy1", chk_busy1, 0);
        checkOutput("rst_async_busy2", chk_busy2, 0);
        checkOutput("rst_async_idle", idle, 1);
        checkOutput("rst_async_err", rsv_err, 0);
        checkOutput("rst_async_waddr", rf_waddr, 0);
        #5;
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Writer-side companion of the integer register file. It merges two write-back sources, ALU/execute results and load returns, onto the single register-file write port through a registered output stage. It also holds a per-register pending-write scoreboard that issue logic queries for RAW/WAW hazards. It sits between the EXE/MEM stages and the register file write port (wen/waddr/wdata).

Parameters:
REGI_DEPTH, 32, number of architectural registers; register 0 is hard-wired zero
DATA_WIDTH, 64, write data width
STARVE_LIMIT, 4, consecutive cycles an ex request may lose arbitration before it is granted priority

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
ex_valid  input  1  execute-result write request
ex_ready  output  1  execute request accepted this cycle
ex_waddr  input  $clog2(REGI_DEPTH)  execute destination register
ex_wdata  input  DATA_WIDTH  execute result
ld_valid  input  1  load-return write request
ld_ready  output  1  load request accepted this cycle
ld_waddr  input  $clog2(REGI_DEPTH)  load destination register
ld_wdata  input  DATA_WIDTH  load data
rsv_valid  input  1  issue stage reserves a destination register
rsv_addr  input  $clog2(REGI_DEPTH)  register being reserved
chk_addr1  input  $clog2(REGI_DEPTH)  hazard query address 1
chk_addr2  input  $clog2(REGI_DEPTH)  hazard query address 2
chk_busy1  output  1  chk_addr1 has a pending write
chk_busy2  output  1  chk_addr2 has a pending write
rf_wen  output  1  register-file write enable
rf_waddr  output  $clog2(REGI_DEPTH)  register-file write address
rf_wdata  output  DATA_WIDTH  register-file write data
rsv_err  output  1  sticky flag: reservation of an already-busy register
idle  output  1  no pending writes and no write in flight

Behaviour:
- Reset (rst=0, asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits=0, starve counter=0, rsv_err=0. Outputs hold these values until the first rising edge after rst returns to 1.
- A handshake fires when valid&ready. At most one source is accepted per cycle.
- Arbitration (combinational ready):
  - Default: ld has priority. ld_ready=1 and ex_ready=!ld_valid.
  - If starve counter == STARVE_LIMIT: ex_ready=1 and ld_ready=!ex_valid.
- Starve counter:
  - Increments when ex_valid&!ex_ready.
  - Clears on an ex handshake or when ex_valid=0.
  - Saturates at STARVE_LIMIT.
- Output stage, 1-cycle latency: on the edge where a handshake fires, the winner's addr/data load into rf_waddr/rf_wdata. rf_wen<=1 when the winner's addr!=0, else 0.
  - With no handshake, rf_wen<=0; rf_waddr/rf_wdata hold their values.
  - Writes to register 0 complete the handshake but never raise rf_wen and never touch the scoreboard.
- Register file captures the write at the edge following rf_wen=1 (edge N+1 for a handshake at edge N).
- Scoreboard, busy[REGI_DEPTH]:
  - Set at the edge where rsv_valid=1 and rsv_addr!=0.
  - Cleared at the edge where rf_wen=1 for rf_waddr. This is the same edge the register file commits, so busy=0 implies the register-file contents are current.
  - Simultaneous set and clear of the same address: set wins, busy stays 1.
  - rsv_valid to an already-busy address (clear not coincident): busy stays 1 and rsv_err<=1 (sticky until reset). Issue logic must stall on busy destinations.
- chk_busy1/2: combinational busy[chk_addrN]; forced to 0 for address 0. Reflect state before the current edge; no same-cycle forwarding of rsv_valid.
- idle = (all busy==0) & !rf_wen.
- Write requests to non-busy registers are legal: written, scoreboard unchanged.
- rst asserted mid-operation discards the in-flight write and all reservations immediately.

Test Plan:
- Reset then single ex write, ex_waddr=5, ex_wdata=0xDEAD_BEEF -> ex_ready=1 at request; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_wen=0.
- Scoreboard: rsv 7 at cycle 0 -> chk_busy1(7)=1 from cycle 1; ld write to 7 handshakes at cycle 3 -> rf_wen at cycle 4, chk_busy1=0 from cycle 5; idle=1 at cycle 5.
- Starvation: ld_valid and ex_valid held 1 for 8 cycles -> ld wins 4 cycles, ex granted on the 5th (ld_ready=0 that cycle), counter resets, then ld wins again.
- Register 0: ex write to addr 0 with data 0x1234 -> ex_ready=1, rf_wen stays 0; rsv to 0 -> chk_busy for 0 stays 0, rsv_err stays 0.
- Boundary: rsv 3 on the same edge rf_wen clears 3 -> busy(3)=1 afterwards; a second rsv 3 while busy -> rsv_err=1 and stays 1 until reset.
- Reset mid-op: rst=0 while rf_wen=1 and busy(9)=1 -> rf_wen=0, chk_busy=0, idle=1 immediately, without waiting for a clock edge.
